// File: rtl/mod_addsub_pkg.sv
// Shared types and dual-rail encoding for the modular add/sub pipeline stages.
package mod_addsub_pkg;

    typedef logic [1:0] dr_pair_t;

    localparam int unsigned DR_TRUE_IDX = 0;
    localparam int unsigned DR_COMP_IDX = 1;

    localparam dr_pair_t DR_SPACER = 2'b00;
    localparam dr_pair_t DR_ZERO   = 2'b10;
    localparam dr_pair_t DR_ONE    = 2'b01;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} stage_state_t;

    function automatic dr_pair_t dr_encode(input logic v);
        return v ? DR_ONE : DR_ZERO;
    endfunction

endpackage

// File: rtl/dr_gen_cell.sv
// One-bit dual-rail generator: carry-generate and half-sum of x and (y ^ s).
module dr_gen_cell
    import mod_addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic s,
    output logic b_0,
    output logic b_1,
    output logic a_0,
    output logic a_1
);

    logic     y_eff;
    dr_pair_t b_pair;
    dr_pair_t a_pair;

    always_comb begin
        y_eff  = y ^ s;
        b_pair = dr_encode(x & y_eff);
        a_pair = dr_encode(x ^ y_eff);
        b_0    = b_pair[DR_TRUE_IDX];
        b_1    = b_pair[DR_COMP_IDX];
        a_0    = a_pair[DR_TRUE_IDX];
        a_1    = a_pair[DR_COMP_IDX];
    end

endmodule

// File: rtl/mod_addsub_stage1_pipe.sv
// First stage of the modular adder/subtractor: per-bit dual-rail codewords behind a
// valid/ready interface with a two-entry skid buffer (main M, skid K).
module mod_addsub_stage1_pipe
    import mod_addsub_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          SPACER_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_s,
    output logic [WIDTH-1:0] b_0,
    output logic [WIDTH-1:0] b_1,
    output logic [WIDTH-1:0] a_0,
    output logic [WIDTH-1:0] a_1
);

    typedef struct packed {
        logic             s;
        logic [WIDTH-1:0] b0;
        logic [WIDTH-1:0] b1;
        logic [WIDTH-1:0] a0;
        logic [WIDTH-1:0] a1;
    } word_t;

    word_t        new_word;
    word_t        m_q, m_d;
    word_t        k_q, k_d;
    stage_state_t state_q, state_d;
    logic         in_fire;
    logic         out_fire;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        dr_gen_cell u_cell (
            .x   (x[i]),
            .y   (y[i]),
            .s   (s),
            .b_0 (new_word.b0[i]),
            .b_1 (new_word.b1[i]),
            .a_0 (new_word.a0[i]),
            .a_1 (new_word.a1[i])
        );
    end
    assign new_word.s = s;

    // Handshake flags come from the registered state only, so in_ready never
    // depends combinationally on out_ready.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    m_d     = new_word;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    k_d     = new_word;
                    state_d = TWO;
                end else if (!in_fire && out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire && out_fire) begin
                    m_d = new_word;
                end
            end
            TWO: begin
                if (out_fire) begin
                    m_d     = k_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            m_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        out_s = m_q.s;
        b_0   = m_q.b0;
        b_1   = m_q.b1;
        a_0   = m_q.a0;
        a_1   = m_q.a1;
        if (SPACER_EN && !out_valid) begin
            b_0 = '0;
            b_1 = '0;
            a_0 = '0;
            a_1 = '0;
        end
    end

endmodule

// File: tb/tb_mod_addsub_stage1_pipe.sv
// Scoreboard bench for mod_addsub_stage1_pipe: driver pushes expected words, monitor pops.
module tb_mod_addsub_stage1_pipe;

    typedef struct packed {
        logic       s;
        logic [3:0] b;
        logic [3:0] a;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       s = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_s;
    logic [3:0] b_0, b_1, a_0, a_1;

    logic       in8_valid = 1'b0;
    logic       in8_ready;
    logic       s8 = 1'b0;
    logic [7:0] x8 = '0;
    logic [7:0] y8 = '0;
    logic       out8_valid;
    logic       out8_ready = 1'b1;
    logic       out8_s;
    logic [7:0] b8_0, b8_1, a8_0, a8_1;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    bit   ready_rand = 1'b0;
    bit   ready_force = 1'b1;
    bit   prev_stall = 1'b0;
    logic [16:0] prev_word = '0;

    mod_addsub_stage1_pipe #(.WIDTH(4), .SPACER_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .s(s),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .b_0(b_0), .b_1(b_1), .a_0(a_0), .a_1(a_1)
    );

    mod_addsub_stage1_pipe #(.WIDTH(8), .SPACER_EN(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in8_valid), .in_ready(in8_ready), .s(s8),
        .x(x8), .y(y8), .out_valid(out8_valid), .out_ready(out8_ready), .out_s(out8_s),
        .b_0(b8_0), .b_1(b8_1), .a_0(a8_0), .a_1(a8_1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] xx, input logic [3:0] yy, input logic ss);
        logic [3:0] yp;
        exp_t e;
        yp  = yy ^ {4{ss}};
        e.s = ss;
        e.b = xx & yp;
        e.a = xx ^ yp;
        return e;
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on each output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("no_11_pair", 64'((b_0 & b_1) | (a_0 & a_1)), 64'd0);
            if (!out_valid) check("spacer", 64'({b_0, b_1, a_0, a_1}), 64'd0);
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_stable", 64'({out_s, b_0, b_1, a_0, a_1}), 64'(prev_word));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_word", 64'({out_s, b_0, b_1, a_0, a_1}),
                          64'({e.s, e.b, ~e.b, e.a, ~e.a}));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_s, b_0, b_1, a_0, a_1};
        end
    end

    // Call at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [3:0] xx, input logic [3:0] yy, input logic ss,
                        input exp_t e);
        int  n = 0;
        bit  done = 1'b0;
        x = xx; y = yy; s = ss; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            if (!done && n > 100) begin
                check("send_timeout", 64'd1, 64'd0);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drained", 64'((sb.size() != 0) || out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rx, ry;
        logic       rs;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_s", 64'(out_s), 64'd0);
        check("rst_rails", 64'({b_0, b_1, a_0, a_1}), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Add and subtract of the same operands, 1-cycle latency from empty.
        send(4'b0101, 4'b0011, 1'b0, '{s: 1'b0, b: 4'b0001, a: 4'b0110});
        check("lat_add", 64'(out_valid), 64'd1);
        wait_drain();
        send(4'b0101, 4'b0011, 1'b1, '{s: 1'b1, b: 4'b0100, a: 4'b1001});
        check("lat_sub", 64'(out_valid), 64'd1);
        wait_drain();

        // A, B fill M and K under backpressure; C must wait.
        ready_force = 1'b0;
        send(4'b1010, 4'b0110, 1'b0, '{s: 1'b0, b: 4'b0010, a: 4'b1100});
        send(4'b1111, 4'b0001, 1'b1, '{s: 1'b1, b: 4'b1110, a: 4'b0001});
        check("full_in_ready", 64'(in_ready), 64'd0);
        x = 4'b0011; y = 4'b0011; s = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        ready_force = 1'b1;
        fork
            send(4'b0011, 4'b0011, 1'b1, '{s: 1'b1, b: 4'b0000, a: 4'b1111});
            repeat (3) begin
                @(negedge clk);
                check("no_gap", 64'(out_valid), 64'd1);
            end
        join
        wait_drain();

        // Random traffic with random backpressure.
        ready_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            send(rx, ry, rs, model(rx, ry, rs));
        end
        ready_rand = 1'b0;
        ready_force = 1'b1;
        @(posedge clk); #1;
        wait_drain();

        // Asynchronous reset while full.
        ready_force = 1'b0;
        @(posedge clk); #1;
        send(4'b0110, 4'b0101, 1'b0, model(4'b0110, 4'b0101, 1'b0));
        send(4'b1001, 4'b0111, 1'b1, model(4'b1001, 4'b0111, 1'b1));
        check("two_in_ready", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_rails", 64'({b_0, b_1, a_0, a_1}), 64'd0);
        check("arst_out_s", 64'(out_s), 64'd0);
        sb.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        ready_force = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_empty", 64'(out_valid), 64'd0);
        send(4'b1100, 4'b1010, 1'b0, '{s: 1'b0, b: 4'b1000, a: 4'b0110});
        check("post_rst_lat", 64'(out_valid), 64'd1);
        wait_drain();

        // Width-8 corner: all ones in add and subtract mode.
        x8 = 8'hFF; y8 = 8'hFF; s8 = 1'b0; in8_valid = 1'b1;
        @(posedge clk); #1;
        check("w8_add_valid", 64'(out8_valid), 64'd1);
        check("w8_add_rails", 64'({out8_s, b8_0, b8_1, a8_0, a8_1}),
              64'({1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF}));
        s8 = 1'b1;
        @(posedge clk); #1;
        in8_valid = 1'b0;
        check("w8_sub_valid", 64'(out8_valid), 64'd1);
        check("w8_sub_rails", 64'({out8_s, b8_0, b8_1, a8_0, a8_1}),
              64'({1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00}));
        @(posedge clk); #1;
        check("w8_spacer", 64'({out8_valid, b8_0, b8_1, a8_0, a8_1}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
